riscv_muldiv_unit: RTL
======================

// Module: riscv_muldiv_unit
// PURPOSE
//  Parametrised iterative RV32M multiply/divide unit; successor to the single-cycle ALU.
//  Executes all 8 M-extension ops (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU) one bit per cycle.
//  Sits beside the ALU in the datapath; the controller stalls the PC while busy=1.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; even, >=4. Iteration count is WIDTH.
// PORTS
//  clk     in   1      clock, rising edge
//  reset   in   1      asynchronous, active-high; clears all state
//  start   in   1      request; sampled only while busy=0
//  op      in   3      funct3: 000 MUL,001 MULH,010 MULHSU,011 MULHU,100 DIV,101 DIVU,110 REM,111 REMU
//  a       in   WIDTH  operand rs1 (dividend / multiplicand)
//  b       in   WIDTH  operand rs2 (divisor / multiplier)
//  busy    out  1      high from the edge after accepted start until the edge after done
//  done    out  1      one-cycle pulse; result valid in that cycle
//  result  out  WIDTH  result; held stable from done until the next accepted start
// BEHAVIOUR
//  Reset: state=IDLE, busy=0, done=0, result=0, counter=0. Reset mid-operation aborts it;
//   no done is produced for the aborted op.
//  States: IDLE, MUL, DIV, DONE. busy=1 in MUL/DIV/DONE; done=1 only in DONE.
//  IDLE: start=1 at an edge -> latch op, a, b; then:
//   - op[2]=1 and b==0 -> DONE (fast path). DIV/DIVU q=all-ones; REM/REMU r=a.
//   - op=DIV/REM, a=MIN(1<<WIDTH-1), b=all-ones -> DONE (fast path). DIV q=MIN; REM r=0.
//   - otherwise op[2]=0 -> MUL; op[2]=1 -> DIV. counter=WIDTH.
//  MUL/DIV: each edge performs one iteration and decrements counter; on the edge where
//   counter goes 1->0 the final result is registered and state -> DONE.
//  DONE: done=1 for exactly one cycle; next edge -> IDLE. start in DONE is ignored.
//  Latency (accepting edge to done high): normal ops WIDTH+1 cycles; fast path 1 cycle.
//  Back-to-back: the earliest next start is sampled on the first edge in IDLE after done.
//  start while busy=1 is ignored (no queueing); a, b, op may change freely while busy.
//  Multiply: operands converted to magnitudes per signedness (MULH: a,b signed;
//   MULHSU: a signed, b unsigned; MULHU/MUL: unsigned), 2*WIDTH-bit shift-add product,
//   negated at end when signs differ. MUL returns low WIDTH bits, MULH* the high WIDTH bits.
//  Divide: restoring, on magnitudes for DIV/REM; quotient negated if signs differ;
//   remainder takes the sign of the dividend (truncating division, RISC-V semantics).
//  All arithmetic is modulo 2^WIDTH; no exceptions or flags are raised.
//  X-free: outputs never X after reset, regardless of op or operand values.
// TESTING
//  MUL a=7 b=6 -> done 33 cycles after the accepting edge, result=0x0000002A.
//  MULH a=0x80000000 b=0x80000000 -> result=0x40000000; MULHU a=b=0xFFFFFFFF -> 0xFFFFFFFE.
//  DIV a=-7(0xFFFFFFF9) b=2 -> result=0xFFFFFFFD; REM same operands -> 0xFFFFFFFF.
//  DIVU a=0x1234 b=0 -> done 1 cycle after start, result=0xFFFFFFFF; REMU -> 0x00001234.
//  DIV a=0x80000000 b=0xFFFFFFFF -> result=0x80000000 in 1 cycle; REM -> 0x00000000.
//  Assert start every cycle during a MUL -> exactly one done, every 34 cycles;
//   assert reset at cycle 10 of a DIV -> busy=0, done=0, result=0, no later done pulse.

Source files
------------

// File: rtl/riscv_muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// one bit per cycle, with single-cycle fast paths for divide-by-zero and signed overflow.
module riscv_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0]   ZERO     = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES     = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   MIN      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [2*WIDTH-1:0] ZERO2    = {(2*WIDTH){1'b0}};
    localparam logic [CW-1:0]      CNT_ZERO = CW'(0);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_INIT = CW'(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t              state_r, state_s;
    logic [CW-1:0]       count_r;
    logic [1:0]          op_r;
    logic                neg_r;
    logic [WIDTH-1:0]    opnd_r;
    logic [2*WIDTH-1:0]  prod_r;
    logic [WIDTH-1:0]    result_r;

    logic                a_neg_s, b_neg_s, fast_s, neg_s;
    logic [WIDTH-1:0]    mag_a_s, mag_b_s, fast_res_s;
    logic [WIDTH:0]      mul_sum_s, div_shift_s;
    logic                div_ge_s;
    logic [WIDTH-1:0]    div_diff_s, div_rem_s, div_val_s, final_s;
    logic [2*WIDTH-1:0]  mul_next_s, div_next_s, mul_fin_s;

    // Operand decode at acceptance: magnitudes, result sign and fast-path detection
    always_comb begin
        a_neg_s = a[WIDTH-1] & ((op == 3'b001) | (op == 3'b010) | (op == 3'b100) | (op == 3'b110));
        b_neg_s = b[WIDTH-1] & ((op == 3'b001) | (op == 3'b100) | (op == 3'b110));
        mag_a_s = a_neg_s ? (ZERO - a) : a;
        mag_b_s = b_neg_s ? (ZERO - b) : b;
        neg_s   = (op[2] & op[1]) ? a_neg_s : (a_neg_s ^ b_neg_s);
        fast_s     = 1'b0;
        fast_res_s = ZERO;
        if (op[2] && (b == ZERO)) begin
            fast_s     = 1'b1;
            fast_res_s = op[1] ? a : ONES;
        end else if (op[2] && !op[0] && (a == MIN) && (b == ONES)) begin
            fast_s     = 1'b1;
            fast_res_s = op[1] ? ZERO : MIN;
        end else begin
            fast_s     = 1'b0;
            fast_res_s = ZERO;
        end
    end

    // One iteration step; prod_r holds {acc, multiplier} or {remainder, dividend/quotient}
    always_comb begin
        mul_sum_s   = {1'b0, prod_r[2*WIDTH-1:WIDTH]} + (prod_r[0] ? {1'b0, opnd_r} : {(WIDTH+1){1'b0}});
        mul_next_s  = {mul_sum_s, prod_r[WIDTH-1:1]};
        div_shift_s = {prod_r[2*WIDTH-1:WIDTH], prod_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[WIDTH-1:0] - opnd_r;
        div_rem_s   = div_ge_s ? div_diff_s : div_shift_s[WIDTH-1:0];
        div_next_s  = {div_rem_s, prod_r[WIDTH-2:0], div_ge_s};
        mul_fin_s   = neg_r ? (ZERO2 - mul_next_s) : mul_next_s;
        div_val_s   = op_r[1] ? div_next_s[2*WIDTH-1:WIDTH] : div_next_s[WIDTH-1:0];
        if (state_r == ST_MUL) begin
            final_s = (op_r == 2'b00) ? mul_fin_s[WIDTH-1:0] : mul_fin_s[2*WIDTH-1:WIDTH];
        end else begin
            final_s = neg_r ? (ZERO - div_val_s) : div_val_s;
        end
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (fast_s) begin
                        state_s = ST_DONE;
                    end else if (op[2]) begin
                        state_s = ST_DIV;
                    end else begin
                        state_s = ST_MUL;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_MUL, ST_DIV: begin
                if (count_r == CNT_ONE) begin
                    state_s = ST_DONE;
                end else begin
                    state_s = state_r;
                end
            end
            ST_DONE: state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // Datapath registers: operand capture, iteration, result write-back
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r  <= CNT_ZERO;
            op_r     <= 2'b00;
            neg_r    <= 1'b0;
            opnd_r   <= ZERO;
            prod_r   <= ZERO2;
            result_r <= ZERO;
        end else if (state_r == ST_IDLE && start) begin
            op_r   <= op[1:0];
            neg_r  <= neg_s;
            opnd_r <= op[2] ? mag_b_s : mag_a_s;
            prod_r <= {ZERO, (op[2] ? mag_a_s : mag_b_s)};
            if (fast_s) begin
                count_r  <= CNT_ZERO;
                result_r <= fast_res_s;
            end else begin
                count_r  <= CNT_INIT;
            end
        end else if (state_r == ST_MUL || state_r == ST_DIV) begin
            prod_r  <= (state_r == ST_MUL) ? mul_next_s : div_next_s;
            count_r <= count_r - CNT_ONE;
            if (count_r == CNT_ONE) begin
                result_r <= final_s;
            end
        end
    end

    assign busy   = (state_r != ST_IDLE);
    assign done   = (state_r == ST_DONE);
    assign result = result_r;

endmodule
